// File: rtl/lsu_mem_if.sv
// Load/store initiator for a word-organised data memory: one request at a time,
// sub-word stores as read-modify-write, RV32I load extension and error response.
module lsu_mem_if #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [2:0]   req_funct3,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [N-1:0] resp_rdata,
   output logic         resp_err,
   output logic         mem_we,
   output logic [N-1:0] mem_a,
   output logic [N-1:0] mem_wd,
   input  logic [N-1:0] mem_rd
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t       state_q, state_d;
   logic         we_q, we_d;
   logic [2:0]   funct3_q, funct3_d;
   logic [N-1:0] addr_q, addr_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic [N-1:0] old_q, old_d;
   logic [N-1:0] resp_rdata_q, resp_rdata_d;
   logic         resp_err_q, resp_err_d;
   logic         mem_we_s;
   logic [N-1:0] mem_wd_s;
   logic         bad_s;

   function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b001:  bad = off[0];
         3'b010:  bad = (off != 2'b00);
         3'b100:  bad = we;
         3'b101:  bad = we | off[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [N-1:0] load_ext(input logic [N-1:0] rd, input logic [2:0] f3, input logic [1:0] off);
      logic [N-1:0] sh;
      logic [N-1:0] res;
      sh = rd >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{(N-8){sh[7]}}, sh[7:0]};
         3'b001:  res = {{(N-16){sh[15]}}, sh[15:0]};
         3'b100:  res = {{(N-8){1'b0}}, sh[7:0]};
         3'b101:  res = {{(N-16){1'b0}}, sh[15:0]};
         default: res = rd;
      endcase
      return res;
   endfunction

   function automatic logic [N-1:0] store_merge(input logic [N-1:0] old, input logic [N-1:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
      logic [N-1:0] res;
      res = old;
      case (f3)
         3'b000:  res[{off, 3'b000} +: 8] = wd[7:0];
         3'b001:  res[{off[1], 4'b0000} +: 16] = wd[15:0];
         default: res = wd;
      endcase
      return res;
   endfunction

   assign bad_s = req_bad(req_we, req_funct3, req_addr[1:0]);

   // Next-state, request capture and memory port drive.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      old_d        = old_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we_s     = 1'b0;
      mem_wd_s     = {N{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d         = req_we;
               funct3_d     = req_funct3;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               resp_rdata_d = {N{1'b0}};
               resp_err_d   = bad_s;
               state_d      = bad_s ? S_RESP : S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            old_d = mem_rd;
            if (we_q) begin
               state_d = S_WRITE;
            end else begin
               resp_rdata_d = load_ext(mem_rd, funct3_q, addr_q[1:0]);
               state_d      = S_RESP;
            end
         end
         S_WRITE: begin
            mem_we_s = 1'b1;
            mem_wd_s = store_merge(old_q, wdata_q, funct3_q, addr_q[1:0]);
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= {N{1'b0}};
         wdata_q      <= {N{1'b0}};
         old_q        <= {N{1'b0}};
         resp_rdata_q <= {N{1'b0}};
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         old_q        <= old_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Gating with rst keeps a write from landing on the edge that resets us.
   assign mem_we     = mem_we_s & ~rst;
   assign mem_wd     = mem_wd_s;
   assign mem_a      = {2'b00, addr_q[N-1:2]};
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed plan steps then random traffic
// against a byte-array reference memory.
module tb_lsu_mem_if;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   int total = 0;
   int bad = 0;

   logic [31:0] dmem [0:63];
   logic [7:0]  rbytes [0:255];

   lsu_mem_if #(.N(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = dmem[mem_a[5:0]];
   always @(posedge clk) begin
      if (mem_we) dmem[mem_a[5:0]] <= mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {rbytes[idx*4+3], rbytes[idx*4+2], rbytes[idx*4+1], rbytes[idx*4]};
   endfunction

   // Reference: size from funct3, alignment by modulo, bytes moved one at a time.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int size;
      int a;
      logic legal;
      size  = 1 << f3[1:0];
      a     = int'(addr[7:0]);
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || (a % size != 0);
      rd    = 32'h0;
      if (!err && we) begin
         for (int i = 0; i < size; i++) rbytes[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else if (!err) begin
         for (int i = 0; i < size; i++) rd = rd | (32'(rbytes[a + i]) << (8 * i));
         if (size < 4 && !f3[2] && rd[8 * size - 1])
            rd = rd | ~((32'h1 << (8 * size)) - 32'h1);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rdata, output logic err);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          lat;
      int          writes;
      model(we, f3, addr, wd, exp_rd, exp_err);
      exp_lat = exp_err ? 1 : (we ? 3 : 2);
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("ready_busy", 32'(req_ready), 32'h0);
      lat = 0;
      writes = 0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) begin
            writes++;
            chk("wr_addr", mem_a, {2'b00, addr[31:2]});
            chk("wr_data", mem_wd, ref_word(int'(addr[7:2])));
         end
      end while (!resp_valid && lat < 10);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("write_count", 32'(writes), (we && !exp_err) ? 32'h1 : 32'h0);
      chk("rdata", resp_rdata, exp_rd);
      chk("err", 32'(resp_err), 32'(exp_err));
      rdata = resp_rdata;
      err = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'h1);
         chk("hold_rdata", resp_rdata, exp_rd);
         chk("hold_ready", 32'(req_ready), 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_done", 32'(resp_valid), 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
      for (int i = 0; i < 256; i++) rbytes[i] = 8'h00;
      req_valid = 1'b1;
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;

      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      chk("lw_const", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(er), 32'h0);

      do_req(1'b1, 3'b000, 32'h12, 32'h00000055, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      chk("sb_word", rd, 32'hDE55BEEF);
      do_req(1'b1, 3'b001, 32'h10, 32'h00001234, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      chk("sh_word", rd, 32'hDE551234);

      do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, 0, rd, er);
      do_req(1'b0, 3'b000, 32'h12, 32'h0, 0, rd, er);
      chk("lb", rd, 32'hFFFFFFFF);
      do_req(1'b0, 3'b100, 32'h12, 32'h0, 0, rd, er);
      chk("lbu", rd, 32'h000000FF);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
      chk("lh", rd, 32'hFFFF80FF);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er);
      chk("lhu", rd, 32'h00007F01);

      do_req(1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er);
      chk("err_lw_mis", 32'(er), 32'h1);
      do_req(1'b1, 3'b001, 32'h13, 32'h1111, 0, rd, er);
      chk("err_sh_mis", 32'(er), 32'h1);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
      chk("err_f3_011", 32'(er), 32'h1);
      do_req(1'b1, 3'b100, 32'h10, 32'h22, 0, rd, er);
      chk("err_st_bu", 32'(er), 32'h1);

      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
      chk("bp_rdata", rd, 32'h80FF7F01);

      // SB that gets reset while its write is pending; the word must survive.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'hAA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("in_write", 32'(mem_we), 32'h1);
      rst = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("rstw_mem_we", 32'(mem_we), 32'h0);
      chk("rstw_req_ready", 32'(req_ready), 32'h1);
      chk("rstw_resp_valid", 32'(resp_valid), 32'h0);
      chk("rstw_mem_a", mem_a, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstw_no_resp", 32'(resp_valid), 32'h0);
      chk("rstw_word", dmem[4], 32'h80FF7F01);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      chk("rstw_load", rd, 32'h80FF7F01);

      for (int n = 0; n < 250; n++) begin
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                $urandom, $urandom_range(0, 2), rd, er);
      end
      for (int w = 0; w < 64; w++) chk("final_mem", dmem[w], ref_word(w));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store initiator between the execute stage and the word-organised `data_mem`. It accepts one load or store request at a time over a valid/ready handshake and drives `data_mem`'s WE/A/WD ports. Byte and halfword stores are performed as read-modify-write of the containing word. Load data is sign- or zero-extended per RV32I funct3, and misaligned or illegal accesses return an error response.

## Interface

**Parameters**
- `N`, default 32: data and address width. Fixed at 32 for RV32I.

**Ports**
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept. High only in IDLE.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RV32I width code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `req_addr`, in, N: byte address.
- `req_wdata`, in, N: store data, right-aligned.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: consumer accepts response.
- `resp_rdata`, out, N: extended load data. 0 for stores and errors.
- `resp_err`, out, 1: misaligned or illegal funct3.
- `mem_we`, out, 1: to data_mem WE.
- `mem_a`, out, N: to data_mem A (word index).
- `mem_wd`, out, N: to data_mem WD.
- `mem_rd`, in, N: from data_mem RD (combinational read).

## Operation

**Request capture**
- A request is accepted when `req_valid && req_ready` at a rising edge.
- On accept, `we`, `funct3`, `addr` and `wdata` are registered as `*_q`.

**Legality check** (on accept)
- Illegal funct3: 011, 110, 111, or a store with funct3 bit 2 set.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- An illegal or misaligned request goes straight to RESP with `resp_err=1`. Memory is not touched.

**States**
- **IDLE**: `req_ready=1`. A legal accept goes to READ; an illegal accept goes to RESP.
- **READ**: `mem_a = {2'b00, addr_q[N-1:2]}`. `mem_rd` is captured into `old_q`.
  - Load: `resp_rdata` is formed from `mem_rd`, then go to RESP.
  - Store: go to WRITE.
- **WRITE**:
  - `mem_we=1`, same `mem_a`.
  - `mem_wd` = `old_q` with the selected lane(s) replaced:
    - B: lane addr_q[1:0] ← wdata_q[7:0].
    - H: lane addr_q[1] ← wdata_q[15:0].
    - W: entire word ← wdata_q.
  - Then go to RESP.
- **RESP**: `resp_valid=1`, outputs held stable. `resp_ready=1` at an edge returns to IDLE.

**Load extraction**
- Byte = mem_rd >> (8·addr_q[1:0]), low 8 bits.
- Half = mem_rd >> (16·addr_q[1]), low 16 bits.
- B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes through.

**Output defaults**
- `mem_we=0` outside WRITE.
- `mem_wd=0` outside WRITE.
- `mem_a` = word index of `addr_q` in every state.

**Reset** (asynchronous)
- State goes to IDLE.
- All `*_q`, `old_q`, `resp_rdata` and `resp_err` clear to 0.
- Outputs after reset: `req_ready=1`, `resp_valid=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- Reset asserted during WRITE drops `mem_we` combinationally before the edge, so no write occurs. The in-flight request is discarded with no response.

## Timing

- Accept at edge k.
  - Load: READ during cycle k+1, `resp_valid` from cycle k+2.
  - Store: READ in k+1, WRITE in k+2 (data_mem updates at the end of k+2), `resp_valid` from cycle k+3.
  - Error: `resp_valid` from cycle k+1.
- `resp_valid` holds until `resp_ready` is sampled high. IDLE follows on the next cycle.
- Minimum accept-to-accept spacing:
  - Load: 3 cycles.
  - Store: 4 cycles.
  - Error: 2 cycles.
- `req_ready` stays 0 from the accept edge until the block returns to IDLE. Requests arriving meanwhile are held off, never dropped.
- A load following a store to the same word sees the new data, because the store's write completes before the block re-enters IDLE.
- `resp_ready` high during READ or WRITE has no effect. Only RESP consumes it.

## Test plan

1. **Reset.** Assert `rst` mid-cycle with `req_valid=1` → immediately `req_ready=1`, `resp_valid=0`, `mem_we=0`, `mem_a=0`. Release and verify no write occurred.
2. **SW then LW.** SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10 → `mem_we` pulses once with A=4, WD=0xDEADBEEF. Load returns 0xDEADBEEF, `resp_err=0`.
3. **Sub-word stores.** Word 4 = 0xDEADBEEF. SB addr 0x12 data 0x55 → word becomes 0xDE55BEEF. SH addr 0x10 data 0x1234 → word becomes 0xDE551234.
4. **Load extension.** Word 4 = 0x80FF7F01:
   - LB 0x12 → 0xFFFFFFFF.
   - LBU 0x12 → 0x000000FF.
   - LH 0x12 → 0xFFFF80FF.
   - LHU 0x10 → 0x00007F01.
5. **Errors.** Each of the following → `resp_err=1` one cycle after accept, with `mem_we` never high:
   - LW 0x11.
   - SH 0x13.
   - funct3=011.
   - store with funct3=100.
6. **Back-pressure and reset during WRITE.**
   - Hold `resp_ready=0` for 5 cycles → `resp_valid` and `resp_rdata` stay stable, `req_ready=0`.
   - Assert `rst` during the WRITE of an SB → target word unchanged.
